if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue_if.sv | 27 ++
 rtl/if_id_queue.sv | 95 +++++++++
 tb/tb_if_id_queue.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// Handshake bundle between instruction fetch and decode around the IF/ID queue.
// The queue takes the slave modport; the fetch/decode side takes the master modport.
interface if_id_queue_if;
    logic        in_valid;
    logic [31:0] in_PC;
    logic [31:0] in_PC4;
    logic [31:0] in_Inst;
    logic        in_ready;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_PC;
    logic [31:0] out_PC4;
    logic [31:0] out_Inst;
    logic [4:0]  out_exc;
    logic [1:0]  count;

    modport slave (
        input  in_valid, in_PC, in_PC4, in_Inst, flush, out_ready,
        output in_ready, out_valid, out_PC, out_PC4, out_Inst, out_exc, count
    );

    modport master (
        output in_valid, in_PC, in_PC4, in_Inst, flush, out_ready,
        input  in_ready, out_valid, out_PC, out_PC4, out_Inst, out_exc, count
    );
endinterface

// File: rtl/if_id_queue.sv
// Two-entry IF/ID decoupling queue.
// Fetch addresses are checked on entry; a bad address is tagged AdEL and its instruction becomes a nop.
module if_id_queue #(
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input logic            clk,
    input logic            reset,
    if_id_queue_if.slave   bus
);
    localparam logic [4:0]  ExcNone = 5'd0;
    localparam logic [4:0]  ExcAdel = 5'd4;
    // 33-bit end address so a memory reaching the top of the address space cannot wrap.
    localparam logic [32:0] ImEnd   = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

    logic [31:0] pc_q   [2];
    logic [31:0] pc4_q  [2];
    logic [31:0] inst_q [2];
    logic [4:0]  exc_q  [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;

    logic        push;
    logic        pop;
    logic        addr_bad;
    logic [4:0]  in_exc;
    logic [1:0]  count_d;

    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.count     = count_q;

    assign push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

    always_comb begin
        addr_bad = (bus.in_PC[1:0] != 2'b00) ||
                   (bus.in_PC < IM_BASE) ||
                   ({1'b0, bus.in_PC} >= ImEnd);
        in_exc   = addr_bad ? ExcAdel : ExcNone;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_comb begin
        bus.out_PC   = 32'd0;
        bus.out_PC4  = 32'd0;
        bus.out_Inst = 32'd0;
        bus.out_exc  = ExcNone;
        if (count_q != 2'd0) begin
            bus.out_PC   = pc_q[rd_ptr_q];
            bus.out_PC4  = pc4_q[rd_ptr_q];
            bus.out_Inst = inst_q[rd_ptr_q];
            bus.out_exc  = exc_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                pc_q[i]   <= 32'd0;
                pc4_q[i]  <= 32'd0;
                inst_q[i] <= 32'd0;
                exc_q[i]  <= ExcNone;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (bus.flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                pc_q[wr_ptr_q]   <= bus.in_PC;
                pc4_q[wr_ptr_q]  <= bus.in_PC4;
                inst_q[wr_ptr_q] <= addr_bad ? 32'd0 : bus.in_Inst;
                exc_q[wr_ptr_q]  <= in_exc;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for the IF/ID queue: reset, push/pop ordering, address faults, flush and
// asynchronous reset mid-operation.
module tb_if_id_queue;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    if_id_queue_if bus ();

    if_id_queue #(
        .IM_BASE  (32'h0000_3000),
        .IM_WORDS (4096)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_PC     = pc;
        bus.in_PC4    = pc + 32'd4;
        bus.in_Inst   = inst;
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_pc", bus.out_PC, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single push into an empty queue: visible after one edge.
        drive(1'b1, 32'h3000, 32'h2408_0001, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("push1_valid", 32'(bus.out_valid), 32'd1);
        check("push1_inst", bus.out_Inst, 32'h2408_0001);
        check("push1_exc", 32'(bus.out_exc), 32'd0);
        check("push1_count", 32'(bus.count), 32'd1);
        check("push1_pc4", bus.out_PC4, 32'h3004);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("pop1_count", 32'(bus.count), 32'd0);
        check("pop1_pc_zero", bus.out_PC, 32'd0);

        // Fill to two; the third push must be refused.
        drive(1'b1, 32'h3000, 32'h1111_0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3004, 32'h1111_0004, 1'b0, 1'b0);
        tick();
        check("full_count", 32'(bus.count), 32'd2);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 32'h3008, 32'h1111_0008, 1'b0, 1'b0);
        tick();
        check("full_hold_count", 32'(bus.count), 32'd2);
        check("full_head_pc", bus.out_PC, 32'h3000);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        check("drain1_pc", bus.out_PC, 32'h3004);
        check("drain1_inst", bus.out_Inst, 32'h1111_0004);
        check("drain1_count", 32'(bus.count), 32'd1);
        check("drain1_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("drain2_count", 32'(bus.count), 32'd0);
        check("drain2_valid", 32'(bus.out_valid), 32'd0);

        // Address faults and range boundaries.
        drive(1'b1, 32'h3002, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        check("misalign_exc", 32'(bus.out_exc), 32'd4);
        check("misalign_inst", bus.out_Inst, 32'd0);
        check("misalign_pc", bus.out_PC, 32'h3002);
        check("misalign_pc4", bus.out_PC4, 32'h3006);
        drive(1'b1, 32'h7000, 32'hDEAD_BEEF, 1'b1, 1'b0);
        tick();
        check("above_exc", 32'(bus.out_exc), 32'd4);
        check("above_pc", bus.out_PC, 32'h7000);
        drive(1'b1, 32'h6FFC, 32'hCAFE_0001, 1'b1, 1'b0);
        tick();
        check("last_word_exc", 32'(bus.out_exc), 32'd0);
        check("last_word_inst", bus.out_Inst, 32'hCAFE_0001);
        drive(1'b1, 32'h2FFC, 32'hCAFE_0002, 1'b1, 1'b0);
        tick();
        check("below_exc", 32'(bus.out_exc), 32'd4);
        check("below_count", 32'(bus.count), 32'd1);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        check("fault_drain_count", 32'(bus.count), 32'd0);

        // Simultaneous push and pop at count 1.
        drive(1'b1, 32'h3000, 32'hAAAA_0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3010, 32'hAAAA_0010, 1'b1, 1'b0);
        tick();
        check("pushpop_count", 32'(bus.count), 32'd1);
        check("pushpop_pc", bus.out_PC, 32'h3010);
        check("pushpop_inst", bus.out_Inst, 32'hAAAA_0010);

        // Flush wins over push and pop at count 2.
        drive(1'b1, 32'h3014, 32'hAAAA_0014, 1'b0, 1'b0);
        tick();
        check("preflush_count", 32'(bus.count), 32'd2);
        drive(1'b1, 32'h3018, 32'hAAAA_0018, 1'b1, 1'b1);
        tick();
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 32'h3020, 32'hBBBB_0020, 1'b0, 1'b0);
        tick();
        check("postflush_pc", bus.out_PC, 32'h3020);
        check("postflush_count", 32'(bus.count), 32'd1);

        // Asynchronous reset between edges with the queue full.
        drive(1'b1, 32'h3024, 32'hBBBB_0024, 1'b0, 1'b0);
        tick();
        check("prereset_count", 32'(bus.count), 32'd2);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_count", 32'(bus.count), 32'd0);
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_pc", bus.out_PC, 32'd0);
        check("async_rst_inst", bus.out_Inst, 32'd0);
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        #2;
        reset = 1'b1;
        drive(1'b1, 32'h3040, 32'hCCCC_0040, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("after_rst_pc", bus.out_PC, 32'h3040);
        check("after_rst_inst", bus.out_Inst, 32'hCCCC_0040);
        check("after_rst_count", 32'(bus.count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
